// File: rtl/regf_pkg.sv
// Shared definitions for the register-file read path: data/address widths
// that must agree with DualPortRegFile, and the burst reader state encoding.
package regf_pkg;

  localparam int REGF_WIDTH = 8;
  localparam int REGF_ADDR  = 15;

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    DRAIN,
    FIN
  } state_t;

endpackage

// File: rtl/regf_rd_skid_fifo.sv
// Two-entry FIFO that buffers register-file read data for the burst reader.
// The head entry is presented continuously; flush empties it in one cycle.
module regf_rd_skid_fifo #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head_data,
  output logic             head_valid,
  output logic [1:0]       count
);

  logic [WIDTH-1:0] mem [2];
  logic             wr_ptr;
  logic             rd_ptr;
  logic [1:0]       count_q;
  logic             do_push;
  logic             do_pop;

  // Refuse pushes into a full FIFO unless a slot frees in the same cycle.
  always_comb begin
    do_pop  = pop && (count_q != 2'd0);
    do_push = push && ((count_q != 2'd2) || do_pop);
  end

  // Storage, pointers and occupancy; push and pop together keep the count.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 2; i++) mem[i] <= '0;
      wr_ptr  <= 1'b0;
      rd_ptr  <= 1'b0;
      count_q <= 2'd0;
    end else if (flush) begin
      wr_ptr  <= 1'b0;
      rd_ptr  <= 1'b0;
      count_q <= 2'd0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= ~wr_ptr;
      end
      if (do_pop) rd_ptr <= ~rd_ptr;
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 2'd1;
        2'b01:   count_q <= count_q - 2'd1;
        default: count_q <= count_q;
      endcase
    end
  end

  assign head_data  = mem[rd_ptr];
  assign head_valid = (count_q != 2'd0);
  assign count      = count_q;

endmodule

// File: rtl/regf_burst_reader.sv
// Burst read client of the configuration register file. Issues sequential
// reads, buffers the registered read data in a 2-entry FIFO and streams the
// bytes out on a valid/ready interface with full backpressure.
// Optional abort support is enabled by defining REGF_BURST_READER_ABORT_EN.
module regf_burst_reader
  import regf_pkg::*;
#(
  parameter int WIDTH = REGF_WIDTH,
  parameter int ADDR  = REGF_ADDR,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [ADDR-1:0]  start_addr,
  input  logic [CNT_W-1:0] byte_count,
  output logic             busy,
  output logic             done,
  output logic             regf_rd_en,
  output logic [ADDR-1:0]  regf_rd_addr,
  input  logic [WIDTH-1:0] regf_data_out,
  output logic [WIDTH-1:0] m_data,
  output logic             m_valid,
  input  logic             m_ready
`ifdef REGF_BURST_READER_ABORT_EN
  ,
  input  logic             abort,
  output logic             aborted
`endif
);

  state_t           state_q, state_d;
  logic [ADDR-1:0]  addr_q;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] issue_cnt;
  logic [CNT_W-1:0] out_cnt;
  logic             inflight_q;
  logic             issue;
  logic             pop;
  logic             abort_hit;
  logic             credit_ok;
  logic [2:0]       occupancy;
  logic [1:0]       fifo_count;
  logic             head_valid;
  logic [WIDTH-1:0] head_data;

`ifdef REGF_BURST_READER_ABORT_EN
  logic aborted_q;
  assign abort_hit = abort && ((state_q == FETCH) || (state_q == DRAIN));
  assign aborted   = (state_q == FIN) && aborted_q;
`else
  assign abort_hit = 1'b0;
`endif

  assign pop = head_valid && m_ready;

  // A read may only go out if its returning byte is sure to have a slot;
  // a head popped this cycle already counts as a free slot.
  always_comb begin
    occupancy = {1'b0, fifo_count} + {2'b00, inflight_q} - {2'b00, pop};
    credit_ok = (occupancy < 3'd2);
  end

  // Next-state, read issue and status outputs.
  always_comb begin
    state_d = state_q;
    issue   = 1'b0;
    busy    = 1'b0;
    done    = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) state_d = (byte_count == '0) ? FIN : FETCH;
      end
      FETCH: begin
        busy = 1'b1;
        if (abort_hit) begin
          state_d = FIN;
        end else if (credit_ok) begin
          issue = 1'b1;
          if ((issue_cnt + CNT_W'(1)) == cnt_q) state_d = DRAIN;
        end
      end
      DRAIN: begin
        busy = 1'b1;
        if (abort_hit) state_d = FIN;
        else if (!inflight_q && ((out_cnt + CNT_W'(pop)) == cnt_q)) state_d = FIN;
      end
      FIN: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State register, address pointer, counters and the in-flight read flag.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      addr_q     <= '0;
      cnt_q      <= '0;
      issue_cnt  <= '0;
      out_cnt    <= '0;
      inflight_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      inflight_q <= issue;
      if ((state_q == IDLE) && start && (byte_count != '0)) begin
        addr_q    <= start_addr;
        cnt_q     <= byte_count;
        issue_cnt <= '0;
        out_cnt   <= '0;
      end else begin
        if (issue) begin
          addr_q    <= addr_q + ADDR'(1);
          issue_cnt <= issue_cnt + CNT_W'(1);
        end
        if (pop) out_cnt <= out_cnt + CNT_W'(1);
      end
    end
  end

`ifdef REGF_BURST_READER_ABORT_EN
  // Remember that the current burst was cut short so FIN can flag it.
  always_ff @(posedge clk) begin
    if (reset) aborted_q <= 1'b0;
    else if (abort_hit) aborted_q <= 1'b1;
    else if (state_q == FIN) aborted_q <= 1'b0;
  end
`endif

  regf_rd_skid_fifo #(
    .WIDTH(WIDTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .flush     (abort_hit),
    .push      (inflight_q && !abort_hit),
    .push_data (regf_data_out),
    .pop       (pop),
    .head_data (head_data),
    .head_valid(head_valid),
    .count     (fifo_count)
  );

  assign regf_rd_en   = issue;
  assign regf_rd_addr = addr_q;
  assign m_valid      = head_valid;
  assign m_data       = head_data;

endmodule
